// File: rtl/mpdmac_axi_pkg.sv
// Shared AXI3 encodings, FSM state codes and small helpers for the mpdmac AXI slave memory.
package mpdmac_axi_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_WDATA = 2'd1;
   localparam state_t ST_WRESP = 2'd2;
   localparam state_t ST_RDATA = 2'd3;

   // WRAP (and the reserved code) step like INCR; only FIXED holds the address.
   function automatic logic burst_advances(input logic [1:0] burst);
      case (burst)
         BURST_FIXED:            return 1'b0;
         BURST_INCR, BURST_WRAP: return 1'b1;
         default:                return 1'b1;
      endcase
   endfunction

   function automatic logic [1:0] resp_of(input logic err);
      return err ? RESP_SLVERR : RESP_OKAY;
   endfunction

endpackage

// File: rtl/mpdmac_axi_mem_array.sv
// Word-addressed scratch array: byte-strobe synchronous write port, asynchronous read port.
module mpdmac_axi_mem_array #(
   parameter int DEPTH_LOG2 = 12,
   parameter int DATA_W     = 32
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [DEPTH_LOG2-1:0] addr,
   input  logic [DATA_W-1:0]     wdata,
   input  logic [DATA_W/8-1:0]   wstrb,
   output logic [DATA_W-1:0]     rdata
);

   logic [DATA_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < DATA_W/8; b++) begin
            if (wstrb[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/mpdmac_axi_slave_mem.sv
// AXI3 slave memory responder, one burst in flight, read/write arbitrated in IDLE.
// Optional out-of-range SLVERR checking is enabled by defining AXI_SLV_SLVERR_EN.
module mpdmac_axi_slave_mem
   import mpdmac_axi_pkg::*;
#(
   parameter int          MEM_DEPTH_LOG2 = 12,
   parameter logic [31:0] BASE_ADDR      = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  awid_i,
   input  logic [31:0] awaddr_i,
   input  logic [3:0]  awlen_i,
   input  logic [2:0]  awsize_i,
   input  logic [1:0]  awburst_i,
   input  logic        awvalid_i,
   output logic        awready_o,
   input  logic [3:0]  wid_i,
   input  logic [31:0] wdata_i,
   input  logic [3:0]  wstrb_i,
   input  logic        wlast_i,
   input  logic        wvalid_i,
   output logic        wready_o,
   output logic [3:0]  bid_o,
   output logic [1:0]  bresp_o,
   output logic        bvalid_o,
   input  logic        bready_i,
   input  logic [3:0]  arid_i,
   input  logic [31:0] araddr_i,
   input  logic [3:0]  arlen_i,
   input  logic [2:0]  arsize_i,
   input  logic [1:0]  arburst_i,
   input  logic        arvalid_i,
   output logic        arready_o,
   output logic [3:0]  rid_o,
   output logic [31:0] rdata_o,
   output logic [1:0]  rresp_o,
   output logic        rlast_o,
   output logic        rvalid_o,
   input  logic        rready_i
);

   state_t      state;
   logic        prio_wr;
   logic        err_q;
   logic [3:0]  id_q;
   logic [3:0]  len_q;
   logic [3:0]  beat_cnt;
   logic [1:0]  burst_q;
   logic [29:0] woff_q;

   logic [31:0] aw_off;
   logic [31:0] ar_off;
   logic        aw_hs, ar_hs, w_hs, r_hs;
   logic        last_beat;
   logic        in_range;
   logic [31:0] mem_rdata;
   logic        unused_ok;

   assign aw_off    = awaddr_i - BASE_ADDR;
   assign ar_off    = araddr_i - BASE_ADDR;
   assign last_beat = (beat_cnt == len_q);

`ifdef AXI_SLV_SLVERR_EN
   assign in_range = (woff_q[29:MEM_DEPTH_LOG2] == '0);
`else
   assign in_range = 1'b1;
`endif

   assign awready_o = ~rst & (state == ST_IDLE) & awvalid_i & (~arvalid_i | prio_wr);
   assign arready_o = ~rst & (state == ST_IDLE) & arvalid_i & (~awvalid_i | ~prio_wr);
   assign wready_o  = (state == ST_WDATA);
   assign bvalid_o  = (state == ST_WRESP);
   assign rvalid_o  = (state == ST_RDATA);

   assign aw_hs = awvalid_i & awready_o;
   assign ar_hs = arvalid_i & arready_o;
   assign w_hs  = wvalid_i & wready_o;
   assign r_hs  = rvalid_o & rready_i;

   assign bid_o   = id_q;
   assign bresp_o = resp_of(err_q);
   assign rid_o   = id_q;
   assign rdata_o = in_range ? mem_rdata : 32'h0;
   assign rresp_o = rvalid_o ? resp_of(~in_range) : RESP_OKAY;
   assign rlast_o = rvalid_o & last_beat;

   // Size, write id and wlast carry no information here: beats are always 4 bytes and
   // the burst length alone terminates a write.
   assign unused_ok = ^{aw_off[1:0], ar_off[1:0], awsize_i, arsize_i, wid_i, wlast_i};

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         prio_wr  <= 1'b1;
         err_q    <= 1'b0;
         id_q     <= 4'h0;
         len_q    <= 4'h0;
         beat_cnt <= 4'h0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (aw_hs) begin
                  state    <= ST_WDATA;
                  id_q     <= awid_i;
                  len_q    <= awlen_i;
                  beat_cnt <= 4'h0;
                  prio_wr  <= 1'b0;
                  err_q    <= 1'b0;
               end else if (ar_hs) begin
                  state    <= ST_RDATA;
                  id_q     <= arid_i;
                  len_q    <= arlen_i;
                  beat_cnt <= 4'h0;
                  prio_wr  <= 1'b1;
               end
            end
            ST_WDATA: begin
               if (wvalid_i) begin
                  err_q <= err_q | ~in_range;
                  if (last_beat) state <= ST_WRESP;
                  else           beat_cnt <= beat_cnt + 4'h1;
               end
            end
            ST_WRESP: begin
               if (bready_i) state <= ST_IDLE;
            end
            ST_RDATA: begin
               if (rready_i) begin
                  if (last_beat) state <= ST_IDLE;
                  else           beat_cnt <= beat_cnt + 4'h1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Address and burst type are datapath: loaded on the address handshake, no reset.
   always_ff @(posedge clk) begin
      if (aw_hs) begin
         woff_q  <= aw_off[31:2];
         burst_q <= awburst_i;
      end else if (ar_hs) begin
         woff_q  <= ar_off[31:2];
         burst_q <= arburst_i;
      end else if ((w_hs || r_hs) && burst_advances(burst_q)) begin
         woff_q <= woff_q + 30'd1;
      end
   end

   mpdmac_axi_mem_array #(
      .DEPTH_LOG2 (MEM_DEPTH_LOG2),
      .DATA_W     (32)
   ) u_mem (
      .clk   (clk),
      .we    (w_hs & in_range),
      .addr  (woff_q[MEM_DEPTH_LOG2-1:0]),
      .wdata (wdata_i),
      .wstrb (wstrb_i),
      .rdata (mem_rdata)
   );

endmodule

// File: tb/tb_mpdmac_axi_slave_mem.sv
// Scoreboard bench for mpdmac_axi_slave_mem: master tasks push expected B/R responses, monitors pop and compare.
module tb_mpdmac_axi_slave_mem;

   localparam int          DEPTH_LOG2 = 12;
   localparam int          DEPTH      = 1 << DEPTH_LOG2;
   localparam logic [31:0] BASE       = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  awid_i;
   logic [31:0] awaddr_i;
   logic [3:0]  awlen_i;
   logic [2:0]  awsize_i;
   logic [1:0]  awburst_i;
   logic        awvalid_i;
   logic        awready_o;
   logic [3:0]  wid_i;
   logic [31:0] wdata_i;
   logic [3:0]  wstrb_i;
   logic        wlast_i;
   logic        wvalid_i;
   logic        wready_o;
   logic [3:0]  bid_o;
   logic [1:0]  bresp_o;
   logic        bvalid_o;
   logic        bready_i;
   logic [3:0]  arid_i;
   logic [31:0] araddr_i;
   logic [3:0]  arlen_i;
   logic [2:0]  arsize_i;
   logic [1:0]  arburst_i;
   logic        arvalid_i;
   logic        arready_o;
   logic [3:0]  rid_o;
   logic [31:0] rdata_o;
   logic [1:0]  rresp_o;
   logic        rlast_o;
   logic        rvalid_o;
   logic        rready_i;

   always #5 clk = ~clk;

   mpdmac_axi_slave_mem #(.MEM_DEPTH_LOG2(DEPTH_LOG2), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rst(rst),
      .awid_i(awid_i), .awaddr_i(awaddr_i), .awlen_i(awlen_i), .awsize_i(awsize_i),
      .awburst_i(awburst_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
      .wid_i(wid_i), .wdata_i(wdata_i), .wstrb_i(wstrb_i), .wlast_i(wlast_i),
      .wvalid_i(wvalid_i), .wready_o(wready_o),
      .bid_o(bid_o), .bresp_o(bresp_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
      .arid_i(arid_i), .araddr_i(araddr_i), .arlen_i(arlen_i), .arsize_i(arsize_i),
      .arburst_i(arburst_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
      .rid_o(rid_o), .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o),
      .rvalid_o(rvalid_o), .rready_i(rready_i)
   );

   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
   } rbeat_t;

   typedef struct packed {
      logic [3:0] id;
      logic [1:0] resp;
   } bexp_t;

   rbeat_t rd_q[$];
   bexp_t  b_q[$];
   bit     grant_q[$];

   logic [31:0] mem_m [0:DEPTH-1];
   logic [31:0] wbuf  [0:15];
   logic [3:0]  sbuf  [0:15];

   int checks = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic bit in_rng(input int unsigned wo);
`ifdef AXI_SLV_SLVERR_EN
      return wo < DEPTH;
`else
      return (wo == wo);
`endif
   endfunction

   // R monitor: every presented beat must match the head of the queue; pop on acceptance.
   always @(negedge clk) begin
      rbeat_t e;
      if (!rst && rvalid_o) begin
         if (rd_q.size() == 0) begin
            check_eq("r_unexpected", 32'd1, 32'd0);
         end else begin
            e = rd_q[0];
            check_eq("rdata", rdata_o, e.data);
            check_eq("rresp", {30'd0, rresp_o}, {30'd0, e.resp});
            check_eq("rlast", {31'd0, rlast_o}, {31'd0, e.last});
            check_eq("rid", {28'd0, rid_o}, {28'd0, e.id});
            if (rready_i) void'(rd_q.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      bexp_t e;
      if (!rst && bvalid_o && bready_i) begin
         if (b_q.size() == 0) begin
            check_eq("b_unexpected", 32'd1, 32'd0);
         end else begin
            e = b_q.pop_front();
            check_eq("bid", {28'd0, bid_o}, {28'd0, e.id});
            check_eq("bresp", {30'd0, bresp_o}, {30'd0, e.resp});
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (awvalid_i && arvalid_i) check_eq("both_ready", {31'd0, awready_o & arready_o}, 32'd0);
         if (awvalid_i && awready_o) grant_q.push_back(1'b1);
         if (arvalid_i && arready_o) grant_q.push_back(1'b0);
      end
   end

   task automatic axi_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [1:0] burst, input int abort_after);
      int unsigned wo;
      bit ok;
      bit err;
      awid_i = id; awaddr_i = addr; awlen_i = len; awburst_i = burst; awsize_i = 3'd2;
      awvalid_i = 1'b1;
      ok = 0;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (awready_o) begin ok = 1; break; end
      end
      check_eq("aw_handshake", {31'd0, ok}, 32'd1);
      @(posedge clk); #1;
      awvalid_i = 1'b0;
      wo = (addr - BASE) >> 2;
      err = 0;
      for (int i = 0; i <= int'(len); i++) begin
         if (i == abort_after) begin
            rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
            check_eq("rst_awready", {31'd0, awready_o}, 32'd0);
            check_eq("rst_wready",  {31'd0, wready_o},  32'd0);
            check_eq("rst_bvalid",  {31'd0, bvalid_o},  32'd0);
            check_eq("rst_arready", {31'd0, arready_o}, 32'd0);
            check_eq("rst_rvalid",  {31'd0, rvalid_o},  32'd0);
            check_eq("rst_bid",     {28'd0, bid_o},     32'd0);
            @(posedge clk); #1;
            rst = 1'b0;
            return;
         end
         wid_i = id; wdata_i = wbuf[i]; wstrb_i = sbuf[i]; wlast_i = (i == int'(len));
         wvalid_i = 1'b1;
         ok = 0;
         for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (wready_o) begin ok = 1; break; end
         end
         check_eq("w_handshake", {31'd0, ok}, 32'd1);
         if (in_rng(wo)) begin
            for (int b = 0; b < 4; b++)
               if (sbuf[i][b]) mem_m[wo % DEPTH][b*8 +: 8] = wbuf[i][b*8 +: 8];
         end else begin
            err = 1;
         end
         @(posedge clk); #1;
         wvalid_i = 1'b0;
         wlast_i = 1'b0;
         if (burst != 2'b00) wo++;
      end
      b_q.push_back('{id: id, resp: (err ? 2'b10 : 2'b00)});
      bready_i = 1'b1;
      ok = 0;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (bvalid_o) begin ok = 1; break; end
      end
      check_eq("b_handshake", {31'd0, ok}, 32'd1);
      @(posedge clk); #1;
      bready_i = 1'b0;
   endtask

   task automatic axi_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, input bit toggle);
      int unsigned wo;
      bit ok;
      int got;
      arid_i = id; araddr_i = addr; arlen_i = len; arburst_i = burst; arsize_i = 3'd2;
      arvalid_i = 1'b1;
      ok = 0;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (arready_o) begin ok = 1; break; end
      end
      check_eq("ar_handshake", {31'd0, ok}, 32'd1);
      wo = (addr - BASE) >> 2;
      for (int i = 0; i <= int'(len); i++) begin
         rd_q.push_back('{id: id,
                          data: (in_rng(wo) ? mem_m[wo % DEPTH] : 32'h0),
                          resp: (in_rng(wo) ? 2'b00 : 2'b10),
                          last: (i == int'(len))});
         if (burst != 2'b00) wo++;
      end
      @(posedge clk); #1;
      arvalid_i = 1'b0;
      got = 0;
      for (int c = 0; c < 400 && got <= int'(len); c++) begin
         rready_i = toggle ? c[0] : 1'b1;
         @(negedge clk);
         if (rvalid_o && rready_i) got++;
         @(posedge clk); #1;
      end
      rready_i = 1'b0;
      check_eq("rd_beats", got, int'(len) + 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      awid_i = '0; awaddr_i = '0; awlen_i = '0; awsize_i = '0; awburst_i = '0; awvalid_i = 1'b0;
      wid_i = '0; wdata_i = '0; wstrb_i = '0; wlast_i = 1'b0; wvalid_i = 1'b0; bready_i = 1'b0;
      arid_i = '0; araddr_i = '0; arlen_i = '0; arsize_i = '0; arburst_i = '0; arvalid_i = 1'b0;
      rready_i = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_eq("reset_awready", {31'd0, awready_o}, 32'd0);
      check_eq("reset_wready",  {31'd0, wready_o},  32'd0);
      check_eq("reset_bvalid",  {31'd0, bvalid_o},  32'd0);
      check_eq("reset_arready", {31'd0, arready_o}, 32'd0);
      check_eq("reset_rvalid",  {31'd0, rvalid_o},  32'd0);
      check_eq("reset_bid",     {28'd0, bid_o},     32'd0);
      check_eq("reset_rid",     {28'd0, rid_o},     32'd0);
      check_eq("reset_bresp",   {30'd0, bresp_o},   32'd0);
      check_eq("reset_rresp",   {30'd0, rresp_o},   32'd0);
      check_eq("reset_rlast",   {31'd0, rlast_o},   32'd0);
      @(posedge clk); #1;

      // Four-beat INCR write then read back.
      for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hA0 + i; sbuf[i] = 4'hF; end
      axi_write(4'd5, 32'h100, 4'd3, 2'b01, -1);
      axi_read(4'd6, 32'h100, 4'd3, 2'b01, 1'b0);

      // Byte-strobe merge.
      wbuf[0] = 32'h1122_3344; sbuf[0] = 4'hF;
      axi_write(4'd1, 32'h40, 4'd0, 2'b01, -1);
      wbuf[0] = 32'hFFFF_FFFF; sbuf[0] = 4'b0101;
      axi_write(4'd2, 32'h40, 4'd0, 2'b01, -1);
      axi_read(4'd3, 32'h40, 4'd0, 2'b01, 1'b0);
      check_eq("merge_word", mem_m[16], 32'h11FF_33FF);

      // Simultaneous AW/AR requests alternate W,R,W,R.
      grant_q.delete();
      for (int k = 0; k < 2; k++) begin
         wbuf[0] = 32'hB000_0000 + k; wbuf[1] = 32'hB100_0000 + k; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
         fork
            axi_write(4'd7, 32'h300, 4'd1, 2'b01, -1);
            axi_read(4'd8, 32'h100, 4'd3, 2'b01, 1'b0);
         join
      end
      check_eq("grant_cnt", grant_q.size(), 32'd4);
      for (int i = 0; i < 4 && i < grant_q.size(); i++)
         check_eq("grant_order", {31'd0, grant_q[i]}, {31'd0, ((i % 2) == 0)});

      // Sixteen-beat read with rready stalls.
      for (int i = 0; i < 16; i++) begin wbuf[i] = 32'hC0DE_0000 + (i * 32'h111); sbuf[i] = 4'hF; end
      axi_write(4'd9, 32'h800, 4'd15, 2'b01, -1);
      axi_read(4'd10, 32'h800, 4'd15, 2'b01, 1'b1);

      // Reset in the middle of a write burst.
      for (int i = 0; i < 8; i++) begin wbuf[i] = 32'h2000_0000 + i; sbuf[i] = 4'hF; end
      axi_write(4'd11, 32'h200, 4'd7, 2'b01, -1);
      for (int i = 0; i < 8; i++) wbuf[i] = 32'hDEAD_0000 + i;
      axi_write(4'd12, 32'h200, 4'd7, 2'b01, 2);
      axi_read(4'd13, 32'h200, 4'd7, 2'b01, 1'b0);

      // Read crossing the top of the array.
      wbuf[0] = 32'hC0FF_EE00; sbuf[0] = 4'hF;
      axi_write(4'd14, 32'h0, 4'd0, 2'b01, -1);
      wbuf[0] = 32'h5A5A_1234;
      axi_write(4'd15, 32'h3FFC, 4'd0, 2'b01, -1);
      axi_read(4'd4, 32'h3FFC, 4'd1, 2'b01, 1'b0);

      repeat (4) @(posedge clk);
      check_eq("rd_q_empty", rd_q.size(), 32'd0);
      check_eq("b_q_empty", b_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
